load_store_unit: RTL and testbench

// - Sits between the RV32I core's execute stage and data_memory (word-wide, 1-cycle registered read, no byte enables).
// - Turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
// - Loads: extracts the byte or half and sign/zero-extends it.
// - SB/SH: performs a read-modify-write; SW is a single write.

---
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte/half/word load-store adapter for a word-wide, 1-cycle-read data memory without byte enables.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests respond at once with resp_error=1.
module load_store_unit #(
  parameter int unsigned RAM_ADDR_BITS = 9,
  parameter int unsigned ADDR_WIDTH    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_error,
  output logic                     mem_enable,
  output logic                     mem_write_enable,
  output logic [RAM_ADDR_BITS-1:0] mem_address,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  typedef enum logic [2:0] {StIdle, StIssue, StCapture, StMerge, StResp} state_e;

  state_e                   state_q;
  logic                     write_q;
  logic [2:0]               funct3_q;
  logic [RAM_ADDR_BITS+1:0] addr_q;
  logic [31:0]              wdata_q;
  logic                     resp_valid_q;
  logic [31:0]              resp_rdata_q;
  logic                     resp_error_q;

  logic        accept;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;
  logic        unused_addr;

  // Address bits above the RAM window wrap and are intentionally dropped.
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:RAM_ADDR_BITS+2];

  assign accept = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = req_funct3[1] ? (req_addr[1:0] != 2'b00) : (req_funct3[0] & req_addr[0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (funct3_q[1]) begin
      ld_ext = mem_rdata;
    end else if (funct3_q[0]) begin
      ld_ext = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
    end else begin
      ld_ext = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
    end
  end

  always_comb begin
    merged = mem_rdata;
    if (funct3_q[0]) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Memory strobes are gated by reset so an interrupted read-modify-write never commits.
  assign req_ready        = (state_q == StIdle) && !reset;
  assign mem_enable       = !reset && ((state_q == StIssue) || (state_q == StMerge));
  assign mem_write_enable = !reset && ((state_q == StMerge) ||
                                       ((state_q == StIssue) && write_q && funct3_q[1]));
  assign mem_address      = addr_q[RAM_ADDR_BITS+1:2];
  assign mem_wdata        = (state_q == StMerge) ? merged : wdata_q;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[RAM_ADDR_BITS+1:0];
            wdata_q  <= req_wdata;
            if (misaligned) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'h0;
              resp_error_q <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          if (write_q && funct3_q[1]) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
          end else if (write_q) begin
            state_q <= StMerge;
          end else begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= ld_ext;
          resp_error_q <= 1'b0;
        end
        StMerge: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0;
          resp_error_q <= 1'b0;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 1-cycle-read word memory.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_enable;
  logic        mem_write_enable;
  logic [8:0]  mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [512];

  int vectors = 0;
  int errors  = 0;

  // Results of the last transaction.
  int          lat;
  int          wr_cnt;
  logic        saw_en;
  logic [31:0] wr_data;
  logic [8:0]  wr_addr;
  logic [31:0] got;
  logic        got_err;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_enable) begin
      if (mem_write_enable) mem[mem_address] <= mem_wdata;
      mem_rdata <= mem[mem_address];
    end
  end

  load_store_unit #(
    .RAM_ADDR_BITS(9),
    .ADDR_WIDTH   (32)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .mem_enable      (mem_enable),
    .mem_write_enable(mem_write_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one request from IDLE and follows it to its response (bounded).
  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    tick();
    req_valid = 1'b0;
    lat     = 1;
    wr_cnt  = 0;
    saw_en  = 1'b0;
    wr_data = 32'h0;
    wr_addr = 9'h0;
    while (!resp_valid && lat < 10) begin
      if (mem_enable) saw_en = 1'b1;
      if (mem_write_enable) begin
        wr_cnt++;
        wr_data = mem_wdata;
        wr_addr = mem_address;
      end
      tick();
      lat++;
    end
    got     = resp_rdata;
    got_err = resp_error;
    check("resp_seen", {31'h0, resp_valid}, 32'h1);
    tick();
    check("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    int acc;
    int nresp;
    int t [3];

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    tick();
    tick();
    check("ready_in_reset", {31'h0, req_ready}, 32'h0);
    reset = 1'b0;
    #1;
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_error", {31'h0, resp_error}, 32'h0);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mem_en", {31'h0, mem_enable}, 32'h0);

    // SW then LW
    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_lat", lat, 2);
    check("sw_wr_cnt", wr_cnt, 1);
    check("sw_wr_data", wr_data, 32'hDEADBEEF);
    check("sw_wr_addr", {23'h0, wr_addr}, 32'h4);
    check("sw_rdata", got, 32'h0);
    txn(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_lat", lat, 3);
    check("lw_data", got, 32'hDEADBEEF);
    check("lw_no_write", wr_cnt, 0);

    // SB read-modify-write and byte loads
    txn(1'b1, 3'b010, 32'h10, 32'h11223344);
    txn(1'b1, 3'b000, 32'h13, 32'h123456A5);
    check("sb_lat", lat, 3);
    check("sb_wr_cnt", wr_cnt, 1);
    check("sb_merge", wr_data, 32'hA5223344);
    txn(1'b0, 3'b000, 32'h13, 32'h0);
    check("lb_13", got, 32'hFFFFFFA5);
    txn(1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_13", got, 32'h000000A5);

    // SH read-modify-write and half loads
    txn(1'b1, 3'b010, 32'h10, 32'h11223344);
    txn(1'b1, 3'b001, 32'h12, 32'hFFFF8001);
    check("sh_merge", wr_data, 32'h80013344);
    txn(1'b0, 3'b001, 32'h12, 32'h0);
    check("lh_12", got, 32'hFFFF8001);
    txn(1'b0, 3'b101, 32'h12, 32'h0);
    check("lhu_12", got, 32'h00008001);
    txn(1'b0, 3'b000, 32'h10, 32'h0);
    check("lb_10", got, 32'h00000044);
    txn(1'b0, 3'b000, 32'h11, 32'h0);
    check("lb_11", got, 32'h00000033);
    txn(1'b0, 3'b001, 32'h10, 32'h0);
    check("lh_10", got, 32'h00003344);
    txn(1'b0, 3'b010, 32'h810, 32'h0);
    check("lw_wrap", got, 32'h80013344);

    // Misaligned word
    txn(1'b0, 3'b010, 32'h11, 32'h0);
`ifdef MISALIGN_TRAP_EN
    check("mis_lat", lat, 1);
    check("mis_err", {31'h0, got_err}, 32'h1);
    check("mis_rdata", got, 32'h0);
    check("mis_no_mem", {31'h0, saw_en}, 32'h0);
`else
    check("mis_lat", lat, 3);
    check("mis_err", {31'h0, got_err}, 32'h0);
    check("mis_rdata", got, 32'h80013344);
`endif
    txn(1'b0, 3'b010, 32'h10, 32'h0);
    check("aligned_err", {31'h0, got_err}, 32'h0);

    // Reset during MERGE of SB 0x10
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h10;
    req_wdata  = 32'h77;
    tick();
    req_valid = 1'b0;
    tick();
    check("merge_we_pre", {31'h0, mem_write_enable}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_merge_we", {31'h0, mem_write_enable}, 32'h0);
    check("rst_merge_en", {31'h0, mem_enable}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_merge_ready", {31'h0, req_ready}, 32'h1);
    nresp = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) nresp++;
      tick();
    end
    check("rst_merge_no_resp", nresp, 0);
    txn(1'b0, 3'b010, 32'h10, 32'h0);
    check("rst_merge_word", got, 32'h80013344);

    // Three back-to-back LWs with req_valid held
    acc   = 0;
    nresp = 0;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    for (int c = 0; c < 20; c++) begin
      if (req_valid && req_ready && acc < 3) begin
        t[acc] = c;
        acc++;
      end
      if (resp_valid) nresp++;
      tick();
      if (acc == 3) req_valid = 1'b0;
    end
    check("b2b_accepts", acc, 3);
    check("b2b_gap0", t[1] - t[0], 4);
    check("b2b_gap1", t[2] - t[1], 4);
    check("b2b_resps", nresp, 3);
    check("b2b_data", resp_rdata, 32'h80013344);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
